// File: rtl/cwc_pkg.sv
// cwc_pkg: state enumeration and state-code constants shared by the capture controller
package cwc_pkg;
  typedef enum logic [2:0] {
    CS_IDLE = 3'd0,
    CS_PRE  = 3'd1,
    CS_WAIT = 3'd2,
    CS_POST = 3'd3,
    CS_DONE = 3'd4
  } cap_state_e;
  localparam logic [2:0] S_IDLE = CS_IDLE;
  localparam logic [2:0] S_PRE  = CS_PRE;
  localparam logic [2:0] S_WAIT = CS_WAIT;
  localparam logic [2:0] S_POST = CS_POST;
  localparam logic [2:0] S_DONE = CS_DONE;
endpackage

// File: rtl/cwc_addr_ctr.sv
// cwc_addr_ctr: trace-RAM write address counter with clear, enable and wrap at DEPTH-1
module cwc_addr_ctr #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] addr
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) addr <= '0;
    else if (clr) addr <= '0;
    else if (en) addr <= (addr == LAST) ? '0 : addr + 1'b1;
endmodule

// File: rtl/cwc_capture_ctrl.sv
// cwc_capture_ctrl: pre/post-trigger trace capture sequencer driving a circular trace RAM.
// Define CWC_STORAGE_QUAL_EN to add the stor_qual input that gates writes and trigger acceptance.
module cwc_capture_ctrl
  import cwc_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic              trig_clk,
  input  logic              trig_rstn,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig_hit,
  input  logic [ADDR_W-1:0] post_len,
`ifdef CWC_STORAGE_QUAL_EN
  input  logic              stor_qual,
`endif
  output logic              wt_ce,
  output logic              wt_en,
  output logic [ADDR_W-1:0] wt_addr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [2:0]        cap_state,
  output logic              done
);
  localparam logic [ADDR_W:0] DEP = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  logic [2:0]      state, nxt;
  logic [ADDR_W:0] plen, plen_in, pre_cnt, post_cnt;
  logic            qual, wr, trig_ok, start, run;
`ifdef CWC_STORAGE_QUAL_EN
  assign qual = stor_qual;
`else
  assign qual = 1'b1;
`endif
  // a write happens in every cycle the registered write enable is high
  assign wr        = wt_en;
  assign start     = arm & ~abort;
  assign trig_ok   = state == S_WAIT && trig_hit && wr;
  assign plen_in   = post_len == '0 ? ONE : {1'b0, post_len} > DEP ? DEP : {1'b0, post_len};
  assign run       = nxt == S_PRE || nxt == S_WAIT || nxt == S_POST;
  assign cap_state = state;
  always_comb begin
    nxt = abort ? S_IDLE
        : arm ? (plen_in == DEP ? S_WAIT : S_PRE)
        : (state == S_PRE && wr && pre_cnt + ONE == DEP - plen) ? S_WAIT
        : trig_ok ? (plen == ONE ? S_DONE : S_POST)
        : (state == S_POST && wr && post_cnt == ONE) ? S_DONE
        : state;
  end
  cwc_addr_ctr #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_addr (
    .clk  (trig_clk),
    .rst_n(trig_rstn),
    .clr  (start),
    .en   (wr & ~abort),
    .addr (wt_addr)
  );
  always_ff @(posedge trig_clk or negedge trig_rstn) begin
    if (!trig_rstn) begin
      state     <= S_IDLE;
      wt_ce     <= 1'b0;
      wt_en     <= 1'b0;
      trig_addr <= '0;
      done      <= 1'b0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      plen      <= ONE;
    end else begin
      state <= nxt;
      wt_ce <= run & qual;
      wt_en <= run & qual;
      done  <= nxt == S_DONE;
      if (start) begin
        plen    <= plen_in;
        pre_cnt <= '0;
      end else if (!abort) begin
        if (state == S_PRE && wr) pre_cnt <= pre_cnt + ONE;
        if (trig_ok) begin
          trig_addr <= wt_addr;
          post_cnt  <= plen - ONE;
        end else if (state == S_POST && wr) post_cnt <= post_cnt - ONE;
      end
    end
  end
endmodule

// File: tb/tb_cwc_capture_ctrl.sv
// tb_cwc_capture_ctrl: directed self-checking bench for cwc_capture_ctrl at DEPTH=16
module tb_cwc_capture_ctrl;
  localparam int AW = 8;
  localparam int DP = 16;
  logic          trig_clk = 1'b0;
  logic          trig_rstn = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          trig_hit = 1'b0;
  logic [AW-1:0] post_len = '0;
`ifdef CWC_STORAGE_QUAL_EN
  logic          stor_qual = 1'b1;
`endif
  logic          wt_ce, wt_en, done;
  logic [AW-1:0] wt_addr, trig_addr;
  logic [2:0]    cap_state;
  int compared = 0;
  int mismatched = 0;

  always #5 trig_clk = ~trig_clk;

  cwc_capture_ctrl #(.ADDR_W(AW), .DEPTH(DP)) dut (
    .trig_clk (trig_clk),
    .trig_rstn(trig_rstn),
    .arm      (arm),
    .abort    (abort),
    .trig_hit (trig_hit),
    .post_len (post_len),
`ifdef CWC_STORAGE_QUAL_EN
    .stor_qual(stor_qual),
`endif
    .wt_ce    (wt_ce),
    .wt_en    (wt_en),
    .wt_addr  (wt_addr),
    .trig_addr(trig_addr),
    .cap_state(cap_state),
    .done     (done)
  );

  task automatic step();
    @(posedge trig_clk);
    #1;
  endtask

  task automatic do_arm(input logic [AW-1:0] len);
    post_len = len;
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    compared++;
    if ({cap_state, wt_ce, wt_en, wt_addr, trig_addr, done} !== '0) begin
      mismatched++;
      $display("FAIL reset_state: got st=%0d ce=%b en=%b addr=%0d taddr=%0d done=%b, want all 0",
               cap_state, wt_ce, wt_en, wt_addr, trig_addr, done);
    end
    trig_rstn = 1'b1;
    trig_hit = 1'b1;
    step();
    step();
    compared++;
    if ({cap_state, wt_en, wt_addr} !== {3'd0, 1'b0, 8'd0}) begin
      mismatched++;
      $display("FAIL idle_ignores_trig: got st=%0d en=%b addr=%0d, want st=0 en=0 addr=0", cap_state, wt_en, wt_addr);
    end
  endtask

  task automatic test_pretrigger();
    trig_hit = 1'b1;
    do_arm(8'd4);
    for (int i = 0; i < 12; i++) begin
      compared++;
      if ({cap_state, wt_en, wt_ce, wt_addr} !== {3'd1, 1'b1, 1'b1, 8'(i)}) begin
        mismatched++;
        $display("FAIL pre_write[%0d]: got st=%0d en=%b ce=%b addr=%0d, want st=1 en=1 ce=1 addr=%0d",
                 i, cap_state, wt_en, wt_ce, wt_addr, i);
      end
      step();
    end
    compared++;
    if ({cap_state, wt_en, wt_addr} !== {3'd2, 1'b1, 8'd12}) begin
      mismatched++;
      $display("FAIL wait_entry: got st=%0d en=%b addr=%0d, want st=2 en=1 addr=12", cap_state, wt_en, wt_addr);
    end
    step();
    compared++;
    if ({cap_state, trig_addr, wt_addr} !== {3'd3, 8'd12, 8'd13}) begin
      mismatched++;
      $display("FAIL trig_accept: got st=%0d taddr=%0d addr=%0d, want st=3 taddr=12 addr=13", cap_state, trig_addr, wt_addr);
    end
    for (int i = 13; i < 16; i++) begin
      compared++;
      if ({cap_state, wt_en, wt_addr} !== {3'd3, 1'b1, 8'(i)}) begin
        mismatched++;
        $display("FAIL post_write[%0d]: got st=%0d en=%b addr=%0d, want st=3 en=1 addr=%0d", i, cap_state, wt_en, wt_addr, i);
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      compared++;
      if ({cap_state, done, wt_ce, wt_en, wt_addr, trig_addr} !== {3'd4, 1'b1, 1'b0, 1'b0, 8'd0, 8'd12}) begin
        mismatched++;
        $display("FAIL done_state[%0d]: got st=%0d done=%b ce=%b en=%b addr=%0d taddr=%0d, want st=4 done=1 ce=0 en=0 addr=0 taddr=12",
                 k, cap_state, done, wt_ce, wt_en, wt_addr, trig_addr);
      end
      step();
    end
  endtask

  task automatic test_plen_zero();
    do_arm(8'd0);
    for (int i = 0; i < 15; i++) begin
      compared++;
      if ({cap_state, wt_en, wt_addr, done} !== {3'd1, 1'b1, 8'(i), 1'b0}) begin
        mismatched++;
        $display("FAIL plen1_pre[%0d]: got st=%0d en=%b addr=%0d done=%b, want st=1 en=1 addr=%0d done=0",
                 i, cap_state, wt_en, wt_addr, done, i);
      end
      step();
    end
    compared++;
    if ({cap_state, wt_en, wt_addr, done} !== {3'd2, 1'b1, 8'd15, 1'b0}) begin
      mismatched++;
      $display("FAIL plen1_wait: got st=%0d en=%b addr=%0d done=%b, want st=2 en=1 addr=15 done=0", cap_state, wt_en, wt_addr, done);
    end
    step();
    compared++;
    if ({cap_state, done, wt_en, wt_addr, trig_addr} !== {3'd4, 1'b1, 1'b0, 8'd0, 8'd15}) begin
      mismatched++;
      $display("FAIL plen1_done: got st=%0d done=%b en=%b addr=%0d taddr=%0d, want st=4 done=1 en=0 addr=0 taddr=15",
               cap_state, done, wt_en, wt_addr, trig_addr);
    end
  endtask

  task automatic test_clamp();
    do_arm(8'd20);
    compared++;
    if ({cap_state, wt_en, wt_addr} !== {3'd2, 1'b1, 8'd0}) begin
      mismatched++;
      $display("FAIL clamp_skip_pre: got st=%0d en=%b addr=%0d, want st=2 en=1 addr=0", cap_state, wt_en, wt_addr);
    end
    step();
    for (int i = 1; i < 16; i++) begin
      compared++;
      if ({cap_state, wt_en, wt_addr, trig_addr} !== {3'd3, 1'b1, 8'(i), 8'd0}) begin
        mismatched++;
        $display("FAIL clamp_post[%0d]: got st=%0d en=%b addr=%0d taddr=%0d, want st=3 en=1 addr=%0d taddr=0",
                 i, cap_state, wt_en, wt_addr, trig_addr, i);
      end
      step();
    end
    compared++;
    if ({cap_state, done, wt_en, wt_addr, trig_addr} !== {3'd4, 1'b1, 1'b0, 8'd0, 8'd0}) begin
      mismatched++;
      $display("FAIL clamp_done: got st=%0d done=%b en=%b addr=%0d taddr=%0d, want st=4 done=1 en=0 addr=0 taddr=0",
               cap_state, done, wt_en, wt_addr, trig_addr);
    end
  endtask

  task automatic test_abort();
    arm = 1'b1;
    abort = 1'b1;
    step();
    arm = 1'b0;
    abort = 1'b0;
    compared++;
    if ({cap_state, done, wt_en} !== {3'd0, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL abort_from_done: got st=%0d done=%b en=%b, want st=0 done=0 en=0", cap_state, done, wt_en);
    end
    do_arm(8'd4);
    repeat (13) step();
    compared++;
    if ({cap_state, wt_addr} !== {3'd3, 8'd13}) begin
      mismatched++;
      $display("FAIL abort_setup: got st=%0d addr=%0d, want st=3 addr=13", cap_state, wt_addr);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    for (int k = 0; k < 2; k++) begin
      compared++;
      if ({cap_state, done, wt_ce, wt_en, wt_addr} !== {3'd0, 1'b0, 1'b0, 1'b0, 8'd13}) begin
        mismatched++;
        $display("FAIL abort_post[%0d]: got st=%0d done=%b ce=%b en=%b addr=%0d, want st=0 done=0 ce=0 en=0 addr=13",
                 k, cap_state, done, wt_ce, wt_en, wt_addr);
      end
      step();
    end
    do_arm(8'd4);
    repeat (5) step();
    arm = 1'b1;
    abort = 1'b1;
    step();
    arm = 1'b0;
    abort = 1'b0;
    compared++;
    if ({cap_state, done, wt_en, wt_addr} !== {3'd0, 1'b0, 1'b0, 8'd5}) begin
      mismatched++;
      $display("FAIL arm_abort_same: got st=%0d done=%b en=%b addr=%0d, want st=0 done=0 en=0 addr=5",
               cap_state, done, wt_en, wt_addr);
    end
  endtask

  task automatic test_reset_mid();
    do_arm(8'd4);
    repeat (13) step();
    trig_rstn = 1'b0;
    #2;
    compared++;
    if ({cap_state, wt_ce, wt_en, wt_addr, trig_addr, done} !== '0) begin
      mismatched++;
      $display("FAIL async_reset: got st=%0d ce=%b en=%b addr=%0d taddr=%0d done=%b, want all 0",
               cap_state, wt_ce, wt_en, wt_addr, trig_addr, done);
    end
    step();
    compared++;
    if ({cap_state, wt_en, wt_addr} !== '0) begin
      mismatched++;
      $display("FAIL reset_hold: got st=%0d en=%b addr=%0d, want all 0", cap_state, wt_en, wt_addr);
    end
    trig_rstn = 1'b1;
    step();
    do_arm(8'd4);
    compared++;
    if ({cap_state, wt_en, wt_addr} !== {3'd1, 1'b1, 8'd0}) begin
      mismatched++;
      $display("FAIL rearm_start: got st=%0d en=%b addr=%0d, want st=1 en=1 addr=0", cap_state, wt_en, wt_addr);
    end
    step();
    compared++;
    if (wt_addr !== 8'd1) begin
      mismatched++;
      $display("FAIL rearm_advance: got addr=%0d, want 1", wt_addr);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

`ifdef CWC_STORAGE_QUAL_EN
  task automatic test_qual();
    int n = 0;
    stor_qual = 1'b1;
    do_arm(8'd4);
    for (int c = 0; c < 64 && cap_state == 3'd1; c++) begin
      if (wt_en) begin
        compared++;
        if (wt_addr !== 8'(n)) begin
          mismatched++;
          $display("FAIL qual_write[%0d]: got addr=%0d, want %0d", n, wt_addr, n);
        end
        n++;
      end
      stor_qual = ~stor_qual;
      step();
    end
    compared++;
    if (n !== 12 || cap_state !== 3'd2) begin
      mismatched++;
      $display("FAIL qual_pre_count: got writes=%0d st=%0d, want writes=12 st=2", n, cap_state);
    end
    stor_qual = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_pretrigger();
    test_plen_zero();
    test_clamp();
    test_abort();
    test_reset_mid();
`ifdef CWC_STORAGE_QUAL_EN
    test_qual();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
